// File: rtl/dmem_responder.sv
// Data-memory responder: RISC-V sized loads/stores against an internal word SRAM,
// answering each accepted access after WAIT_STATES extra cycles with a ready pulse.

module dmem_responder_chk (
   input logic clk,
   input logic reset,
   input logic ready,
   input logic err,
   input logic busy
);

   ap_ready_in_busy: assert property (@(posedge clk) disable iff (!reset) ready |-> busy);
   ap_err_not_busy:  assert property (@(posedge clk) disable iff (!reset) !(err && busy));
   ap_ready_pulse:   assert property (@(posedge clk) disable iff (!reset) ready |=> !ready);
   ap_err_pulse:     assert property (@(posedge clk) disable iff (!reset) err |=> !err);

endmodule

module dmem_responder #(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned ADDR_W      = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic              reade,
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        funct3,
   input  logic [31:0]       wr_data,
   output logic [31:0]       rd_data,
   output logic              ready,
   output logic              err,
   output logic              busy
);

   localparam int unsigned DEPTH    = 2 ** (ADDR_W - 2);
   localparam logic [2:0]  CNT_INIT = 3'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   function automatic logic code_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      case (f3)
         3'b000, 3'b001, 3'b010: ok = 1'b1;
         3'b100, 3'b101:         ok = !is_store;
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic addr_aligned(input logic [1:0] lo, input logic [2:0] f3);
      logic ok;
      case (f3[1:0])
         2'b00:   ok = 1'b1;
         2'b01:   ok = !lo[0];
         2'b10:   ok = (lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] byte_enables(input logic [1:0] lo, input logic [2:0] f3);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << lo;
         2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Store data is replicated across lanes so the byte enables alone pick the target.
   function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [2:0] f3);
      logic [31:0] lanes;
      case (f3[1:0])
         2'b00:   lanes = {4{wd[7:0]}};
         2'b01:   lanes = {2{wd[15:0]}};
         default: lanes = wd;
      endcase
      return lanes;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                               input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (lo)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lo[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  res = {{24{b[7]}}, b};
         3'b001:  res = {{16{h[15]}}, h};
         3'b100:  res = {24'h000000, b};
         3'b101:  res = {16'h0000, h};
         default: res = word;
      endcase
      return res;
   endfunction

   state_t              state_r, state_nx_s;
   logic [2:0]          cnt_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [2:0]          funct3_r;
   logic [31:0]         wdata_r;
   logic                is_wr_r;
   logic [31:0]         rd_data_r;
   logic                ready_r, err_r, busy_r;
   logic                ready_nx_s, err_nx_s, busy_nx_s;
   logic                req_s, req_ok_s, accept_s, reject_s;
   logic                access_s;
   logic [31:0]         rd_word_s, wmask_s, merged_s;
   logic [3:0]          be_s;
   logic [31:0]         mem_r [0:DEPTH-1];

   // Request qualification while idle.
   always_comb begin
      req_s    = wr | reade;
      req_ok_s = !(wr & reade) && code_legal(wr, funct3) && addr_aligned(addr[1:0], funct3);
      accept_s = (state_r == ST_IDLE) && req_s && req_ok_s;
      reject_s = (state_r == ST_IDLE) && req_s && !req_ok_s;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (reject_s) begin
               state_nx_s = ST_ERR;
            end else if (accept_s) begin
               state_nx_s = ST_WAIT;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == 3'd0) begin
               state_nx_s = ST_RESP;
            end else begin
               state_nx_s = ST_WAIT;
            end
         end
         ST_RESP: state_nx_s = ST_IDLE;
         ST_ERR:  state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state, so the pulses come straight off flops.
   always_comb begin
      ready_nx_s = (state_nx_s == ST_RESP);
      err_nx_s   = (state_nx_s == ST_ERR);
      busy_nx_s  = (state_nx_s == ST_WAIT) || (state_nx_s == ST_RESP);
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ready_r <= 1'b0;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         ready_r <= ready_nx_s;
         err_r   <= err_nx_s;
         busy_r  <= busy_nx_s;
      end
   end

   // Array access on the latched request.
   always_comb begin
      access_s  = (state_r == ST_WAIT) && (cnt_r == 3'd0);
      rd_word_s = mem_r[addr_r[ADDR_W-1:2]];
      be_s      = byte_enables(addr_r[1:0], funct3_r);
      wmask_s   = {{8{be_s[3]}}, {8{be_s[2]}}, {8{be_s[1]}}, {8{be_s[0]}}};
      merged_s  = (rd_word_s & ~wmask_s) | (store_lanes(wdata_r, funct3_r) & wmask_s);
   end

   // Request latch, wait counter and load result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_r     <= 3'd0;
         addr_r    <= {ADDR_W{1'b0}};
         funct3_r  <= 3'd0;
         wdata_r   <= 32'd0;
         is_wr_r   <= 1'b0;
         rd_data_r <= 32'd0;
      end else begin
         if (accept_s) begin
            cnt_r    <= CNT_INIT;
            addr_r   <= addr;
            funct3_r <= funct3;
            wdata_r  <= wr_data;
            is_wr_r  <= wr;
         end else if ((state_r == ST_WAIT) && (cnt_r != 3'd0)) begin
            cnt_r <= cnt_r - 3'd1;
         end
         if (access_s && !is_wr_r) begin
            rd_data_r <= load_extend(rd_word_s, addr_r[1:0], funct3_r);
         end
      end
   end

   // SRAM write port; contents survive reset but a reset on the access edge blocks the write.
   always_ff @(posedge clk) begin
      if (reset && access_s && is_wr_r) begin
         mem_r[addr_r[ADDR_W-1:2]] <= merged_s;
      end
   end

   assign rd_data = rd_data_r;
   assign ready   = ready_r;
   assign err     = err_r;
   assign busy    = busy_r;

   dmem_responder_chk u_chk (
      .clk   (clk),
      .reset (reset),
      .ready (ready_r),
      .err   (err_r),
      .busy  (busy_r)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a transaction-level model schedules the
// expected per-cycle outputs, and one negedge process compares them with the DUT.

module tb_dmem_responder;

   localparam int WS = 1;
   localparam int NW = 128;
   localparam int NC = 16384;

   logic        clk = 1'b0;
   logic        reset, wr, reade;
   logic [8:0]  addr;
   logic [2:0]  funct3;
   logic [31:0] wr_data, rd_data;
   logic        ready, err, busy;

   always #5 clk = ~clk;

   dmem_responder #(.WAIT_STATES(WS), .ADDR_W(9)) dut (
      .clk(clk), .reset(reset), .wr(wr), .reade(reade), .addr(addr), .funct3(funct3),
      .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .err(err), .busy(busy)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit          e_ready [NC];
   bit          e_err   [NC];
   bit          e_busy  [NC];
   bit          e_rdset [NC];
   logic [31:0] e_rdval [NC];
   logic [31:0] mmem    [NW];
   logic [31:0] cur_rd = 32'd0;
   bit          chk_en = 1'b0;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit m_legal(bit w, bit r, logic [8:0] a, logic [2:0] f3);
      int sz;
      if (w && r) return 1'b0;
      if (w) begin
         if (f3 > 3'd2) return 1'b0;
      end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
         return 1'b0;
      end
      sz = 1 << f3[1:0];
      return (int'(a) % sz) == 0;
   endfunction

   function automatic logic [31:0] m_load(logic [8:0] a, logic [2:0] f3);
      logic [31:0] word, b, h;
      word = mmem[a / 4];
      b = (word >> (8 * (a % 4))) & 32'h000000FF;
      h = (word >> (8 * (a % 4))) & 32'h0000FFFF;
      case (f3)
         3'd0:    return b[7]  ? (b | 32'hFFFFFF00) : b;
         3'd1:    return h[15] ? (h | 32'hFFFF0000) : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return word;
      endcase
   endfunction

   task automatic m_store(logic [8:0] a, logic [2:0] f3, logic [31:0] d);
      logic [31:0] mask;
      int sh;
      sh   = 8 * (a % 4);
      mask = (f3 == 3'd0) ? 32'h000000FF : (f3 == 3'd1) ? 32'h0000FFFF : 32'hFFFFFFFF;
      mmem[a / 4] = (mmem[a / 4] & ~(mask << sh)) | ((d & mask) << sh);
   endtask

   // Drive one request, schedule the outputs it must produce, then fill the busy window.
   task automatic issue(input bit w, input bit r, input logic [8:0] a, input logic [2:0] f3,
                        input logic [31:0] d, input bit hold, input bit abort);
      int n, k;
      @(negedge clk);
      reset = 1'b1;
      n = cyc + 1;
      wr = w; reade = r; addr = a; funct3 = f3; wr_data = d;
      if (!w && !r) begin
         k = 1;
      end else if (!m_legal(w, r, a, f3)) begin
         e_err[n] = 1'b1;
         k = 2;
      end else begin
         for (int i = 0; i <= WS + 1; i++) e_busy[n + i] = 1'b1;
         if (abort) begin
            e_busy[n + WS + 1]  = 1'b0;
            e_rdset[n + WS + 1] = 1'b1;
            e_rdval[n + WS + 1] = 32'd0;
            k = WS + 2;
         end else begin
            e_ready[n + WS + 1] = 1'b1;
            if (r) begin
               e_rdset[n + WS + 1] = 1'b1;
               e_rdval[n + WS + 1] = m_load(a, f3);
            end else begin
               m_store(a, f3, d);
            end
            k = WS + 3;
         end
      end
      for (int i = 1; i < k; i++) begin
         @(negedge clk);
         if (!hold) begin
            wr = 1'($urandom); reade = 1'($urandom); addr = 9'($urandom);
            funct3 = 3'($urandom); wr_data = $urandom;
         end
         if (abort && i == WS + 1) reset = 1'b0;
      end
   endtask

   // Per-cycle comparison against the scheduled expectations.
   always @(negedge clk) begin
      if (chk_en) begin
         if (e_rdset[cyc]) cur_rd = e_rdval[cyc];
         check("ready", {31'd0, ready}, {31'd0, e_ready[cyc]});
         check("err", {31'd0, err}, {31'd0, e_err[cyc]});
         check("busy", {31'd0, busy}, {31'd0, e_busy[cyc]});
         check("rd_data", rd_data, cur_rd);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0]  a;
      logic [2:0]  f3;
      bit          w, r;
      reset = 1'b0; wr = 1'b0; reade = 1'b0; addr = 9'd0; funct3 = 3'd0; wr_data = 32'd0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rd", rd_data, 32'd0);

      for (int i = 0; i < NW; i++) issue(1'b1, 1'b0, 9'(i * 4), 3'd2, $urandom, 1'b0, 1'b0);

      issue(1'b1, 1'b0, 9'd8, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0);
      check("sw8_ready", {31'd0, ready}, 32'd1);
      issue(1'b0, 1'b1, 9'd8, 3'd2, 32'd0, 1'b0, 1'b0);
      check("lw8_ready", {31'd0, ready}, 32'd1);
      check("lw8", rd_data, 32'hDEADBEEF);
      issue(1'b1, 1'b0, 9'd9, 3'd0, 32'h00000055, 1'b0, 1'b0);
      issue(1'b0, 1'b1, 9'd8, 3'd2, 32'd0, 1'b0, 1'b0);
      check("lw8_after_sb", rd_data, 32'hDEAD55EF);
      issue(1'b0, 1'b1, 9'd11, 3'd0, 32'd0, 1'b0, 1'b0);
      check("lb11", rd_data, 32'hFFFFFFDE);
      issue(1'b0, 1'b1, 9'd11, 3'd4, 32'd0, 1'b0, 1'b0);
      check("lbu11", rd_data, 32'h000000DE);
      issue(1'b0, 1'b1, 9'd10, 3'd1, 32'd0, 1'b0, 1'b0);
      check("lh10", rd_data, 32'hFFFFDEAD);
      issue(1'b0, 1'b1, 9'd8, 3'd5, 32'd0, 1'b0, 1'b0);
      check("lhu8", rd_data, 32'h000055EF);

      issue(1'b0, 1'b1, 9'd6, 3'd2, 32'd0, 1'b0, 1'b0);
      check("misalign_err", {31'd0, err}, 32'd1);
      check("misalign_rd", rd_data, 32'h000055EF);
      issue(1'b1, 1'b1, 9'd8, 3'd2, 32'h0, 1'b0, 1'b0);
      check("both_err", {31'd0, err}, 32'd1);
      issue(1'b0, 1'b1, 9'd8, 3'd3, 32'd0, 1'b0, 1'b0);
      check("f3_011_err", {31'd0, err}, 32'd1);
      issue(1'b0, 1'b1, 9'd8, 3'd2, 32'd0, 1'b0, 1'b0);
      check("lw8_unchanged", rd_data, 32'hDEAD55EF);

      for (int i = 0; i < 5; i++) issue(1'b0, 1'b1, 9'd8, 3'd2, 32'd0, 1'b1, 1'b0);

      issue(1'b1, 1'b0, 9'd4, 3'd2, 32'hCAFEF00D, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 9'd4, 3'd2, 32'h12345678, 1'b0, 1'b1);
      issue(1'b0, 1'b1, 9'd4, 3'd2, 32'd0, 1'b0, 1'b0);
      check("lw4_after_abort", rd_data, 32'hCAFEF00D);

      for (int i = 0; i < 400; i++) begin
         w  = 1'($urandom);
         r  = 1'($urandom);
         a  = 9'($urandom);
         f3 = 3'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            w  = ($urandom_range(0, 1) == 0);
            r  = !w;
            f3 = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
            if (f3 == 3'd3) f3 = 3'd2;
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         end
         issue(w, r, a, f3, $urandom, 1'b0, ($urandom_range(0, 19) == 0));
      end

      issue(1'b0, 1'b0, 9'd0, 3'd0, 32'd0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
